// File: rtl/demux_striping_n.sv
// Round-robin word striper: stages LANES words and publishes them lane-aligned,
// flushing partial stripes after IDLE_FLUSH idle cycles. Optional macro STRIPE_PARITY_EN adds per-lane parity.
module demux_striping_n #(
  parameter int WIDTH      = 32,
  parameter int LANES      = 4,
  parameter int IDLE_FLUSH = 3
) (
  input  logic                       clk_2f,
  input  logic                       reset_L,
  input  logic                       valid_in,
  input  logic [WIDTH-1:0]           data_input,
  output logic [LANES*WIDTH-1:0]     lane_data,
  output logic [LANES-1:0]           valid_out,
  output logic [$clog2(LANES)-1:0]   lane_ptr,
  output logic [LANES-1:0]           stripe_par
);

  localparam int PW = $clog2(LANES);
  localparam int CW = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;

  logic [WIDTH-1:0]       staging [LANES];
  logic [LANES-1:0]       filled;
  logic [CW-1:0]          idle_cnt;
  logic                   last_lane;
  logic                   flush;
  logic                   publish;
  logic [LANES*WIDTH-1:0] pub_bus;
  logic [LANES-1:0]       pub_par;

  assign last_lane = (lane_ptr == PW'(LANES - 1));
  assign flush     = !valid_in && (filled != '0) && (IDLE_FLUSH != 0) &&
                     (idle_cnt == CW'(IDLE_FLUSH - 1));
  assign publish   = (valid_in && last_lane) || flush;

  // The word being accepted this edge merges straight into the published bus;
  // lanes never filled in this stripe publish zero.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign pub_bus[gi*WIDTH +: WIDTH] =
      (valid_in && lane_ptr == PW'(gi)) ? data_input :
      (filled[gi] ? staging[gi] : '0);
    assign pub_par[gi] = ^pub_bus[gi*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L) begin
      lane_data <= '0;
      valid_out <= '0;
      lane_ptr  <= '0;
      filled    <= '0;
      idle_cnt  <= '0;
      for (int i = 0; i < LANES; i++) staging[i] <= '0;
    end else begin
      valid_out <= '0;
      if (valid_in) begin
        staging[lane_ptr] <= data_input;
        idle_cnt          <= '0;
        if (last_lane) begin
          lane_data <= pub_bus;
          valid_out <= '1;
          filled    <= '0;
          lane_ptr  <= '0;
        end else begin
          filled[lane_ptr] <= 1'b1;
          lane_ptr         <= lane_ptr + 1'b1;
        end
      end else if (flush) begin
        lane_data <= pub_bus;
        valid_out <= filled;
        filled    <= '0;
        lane_ptr  <= '0;
        idle_cnt  <= '0;
      end else if (filled != '0 && IDLE_FLUSH != 0) begin
        idle_cnt <= idle_cnt + 1'b1;
      end else begin
        idle_cnt <= '0;
      end
    end
  end

`ifdef STRIPE_PARITY_EN
  always_ff @(posedge clk_2f or negedge reset_L) begin
    if (!reset_L)     stripe_par <= '0;
    else if (publish) stripe_par <= pub_par;
  end
`else
  assign stripe_par = '0;
  logic unused_par;
  assign unused_par = ^{pub_par, publish};
`endif

endmodule

// File: tb/tb_demux_striping_n.sv
// Bench for demux_striping_n: directed test-plan steps then random traffic,
// checked every cycle against a queue-based stripe model.
module tb_demux_striping_n;
  localparam int WIDTH = 32;
  localparam int LANES = 4;
  localparam int IDLE_FLUSH = 3;
  localparam int PW = $clog2(LANES);

  logic                   clk_2f = 1'b0;
  logic                   reset_L = 1'b0;
  logic                   valid_in = 1'b0;
  logic [WIDTH-1:0]       data_input = '0;
  logic [LANES*WIDTH-1:0] lane_data;
  logic [LANES-1:0]       valid_out;
  logic [PW-1:0]          lane_ptr;
  logic [LANES-1:0]       stripe_par;

  int total = 0;
  int bad = 0;

  logic [WIDTH-1:0]       q[$];
  int                     idle = 0;
  logic [LANES*WIDTH-1:0] exp_bus = '0;
  logic [LANES-1:0]       exp_valid = '0;
  logic [LANES-1:0]       exp_par = '0;

  demux_striping_n #(.WIDTH(WIDTH), .LANES(LANES), .IDLE_FLUSH(IDLE_FLUSH)) dut (
    .clk_2f(clk_2f), .reset_L(reset_L), .valid_in(valid_in), .data_input(data_input),
    .lane_data(lane_data), .valid_out(valid_out), .lane_ptr(lane_ptr), .stripe_par(stripe_par)
  );

  always #5 clk_2f = ~clk_2f;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic publish_model();
    logic [WIDTH-1:0] w;
    exp_valid = '0;
    for (int i = 0; i < LANES; i++) begin
      w = (i < q.size()) ? q[i] : '0;
      exp_bus[i*WIDTH +: WIDTH] = w;
      exp_valid[i] = (i < q.size());
`ifdef STRIPE_PARITY_EN
      exp_par[i] = ^w;
`else
      exp_par[i] = 1'b0;
`endif
    end
    q.delete();
    idle = 0;
  endtask

  task automatic model_reset();
    q.delete();
    idle = 0;
    exp_bus = '0;
    exp_valid = '0;
    exp_par = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".lane_data"}, 256'(lane_data), 256'(exp_bus));
    chk({tag, ".valid_out"}, 256'(valid_out), 256'(exp_valid));
    chk({tag, ".lane_ptr"}, 256'(lane_ptr), 256'(q.size()));
    chk({tag, ".stripe_par"}, 256'(stripe_par), 256'(exp_par));
  endtask

  // Drive one cycle, advance the model on the edge, check 1 time unit later.
  task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d);
    valid_in = v;
    data_input = v ? d : WIDTH'($urandom);
    @(posedge clk_2f);
    exp_valid = '0;
    if (v) begin
      q.push_back(d);
      idle = 0;
      if (q.size() == LANES) publish_model();
    end else if (q.size() > 0 && IDLE_FLUSH != 0) begin
      idle++;
      if (idle == IDLE_FLUSH) publish_model();
    end
    #1;
    check_all(tag);
    $display("step %s v=%0b d=%h valid_out=%b lane_ptr=%0d lane_data=%h par=%b",
             tag, v, d, valid_out, lane_ptr, lane_data, stripe_par);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    #12;
    check_all("reset");
    reset_L = 1'b1;
    @(negedge clk_2f);

    step("full0", 1, 32'hFFFFFFFF);
    step("full1", 1, 32'hAAAAAAAA);
    step("full2", 1, 32'hEEEEEEEE);
    step("full3", 1, 32'hCCCCCCCC);
    chk("full.direct", 256'(lane_data), 256'(128'hCCCCCCCC_EEEEEEEE_AAAAAAAA_FFFFFFFF));
    step("full.after", 0, 0);

    step("part0", 1, 32'hAAAAAAAA);
    step("part1", 1, 32'h11111111);
    step("part.idle1", 0, 0);
    step("part.idle2", 0, 0);
    step("part.idle3", 0, 0);
    chk("part.direct_v", 256'(valid_out), 256'(4'b0011));
    chk("part.direct_d", 256'(lane_data), 256'(128'h0_0_11111111_AAAAAAAA));
    step("part.after", 0, 0);

    step("bub0", 1, 32'h01020304);
    step("bub1", 1, 32'h05060708);
    step("bub.idle1", 0, 0);
    step("bub.idle2", 0, 0);
    step("bub2", 1, 32'h99999999);
    step("bub3", 1, 32'h12345678);
    chk("bub.direct_v", 256'(valid_out), 256'(4'b1111));

    step("rst0", 1, 32'hDEAD0001);
    step("rst1", 1, 32'hDEAD0002);
    step("rst2", 1, 32'hDEAD0003);
    reset_L = 1'b0;
    #2;
    model_reset();
    check_all("rst.async");
    #1;
    reset_L = 1'b1;
    step("rst.s0", 1, 32'h00000010);
    step("rst.s1", 1, 32'h00000020);
    step("rst.s2", 1, 32'h00000030);
    step("rst.s3", 1, 32'h00000040);

    for (int i = 1; i <= 8; i++) step("b2b", 1, WIDTH'(i));
    step("par0", 1, 32'h00000001);
    step("par1", 1, 32'h00000003);
    step("par2", 1, 32'h00000000);
    step("par3", 1, 32'h80000000);
`ifdef STRIPE_PARITY_EN
    chk("par.direct", 256'(stripe_par), 256'(4'b1001));
`else
    chk("par.direct", 256'(stripe_par), 256'(4'b0000));
`endif

    for (int i = 0; i < 300; i++) begin
      w = WIDTH'($urandom);
      if ((i % 40) >= 34) step("rnd.idle", 0, 0);
      else step("rnd", ($urandom_range(0, 9) < 6), w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
